// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with two-flop line synchroniser, mid-bit sampling,
// a valid/ready holding register and one-cycle framing-error / overrun pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CW           = 13
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          rx_meta;
    logic          rx_s;

    // Every state waits for the down-counter to hit zero before acting, so the
    // start bit is checked half a bit in and every later bit at its centre.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        count <= HALF_LOAD;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end else if (!rx_s) begin
                        state   <= DATA;
                        count   <= BIT_LOAD;
                        bit_idx <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                DATA: begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end else begin
                        shift   <= {rx_s, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        count   <= BIT_LOAD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end

                STOP: begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end else if (rx_s) begin
                        // A byte consumed in this same cycle frees the register, so no overrun.
                        rx_data  <= shift;
                        rx_valid <= 1'b1;
                        overrun  <= rx_valid && !rx_ready;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= BRK;
                    end
                end

                BRK: begin
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at CLKS_PER_BIT=16: normal frame, glitch rejection,
// framing error with break, back-to-back overrun, and mid-frame reset.
module tb_uart_rx;

    localparam int B = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int fe_count = 0;
    int ov_count = 0;
    int fe_base;
    int ov_base;

    uart_rx #(
        .CLKS_PER_BIT(B),
        .CW(13)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .frame_err(frame_err),
        .overrun(overrun),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts high cycles of the pulse outputs so tests can check pulse totals.
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_count++;
        if (overrun === 1'b1) ov_count++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after edge 0; returns just after edge 9*B with the stop bit on the line.
    task automatic drive_bits(input logic [7:0] data, input logic stop_bit);
        rx = 1'b0;
        tick(B);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            tick(B);
        end
        rx = stop_bit;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rx = 1'b1;
        rx_ready = 1'b0;
        tick(3);
        rst = 1'b0;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tick(4);
    endtask

    task automatic test_basic_frame;
        fe_base = fe_count;
        ov_base = ov_count;
        tick(1);
        drive_bits(8'hA5, 1'b1);
        tick(10);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_edge154: got %b expected 0", rx_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_edge154: got %b expected 1", busy); end
        tick(1);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid_edge155: got %b expected 1", rx_valid); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL basic_data: got %h expected a5", rx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_edge155: got %b expected 0", busy); end
        tick(5);
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid_held: got %b expected 1", rx_valid); end
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_consume: got %b expected 0", rx_valid); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL basic_data_after_consume: got %h expected a5", rx_data); end
        checks++; if (fe_count - fe_base !== 0 || ov_count - ov_base !== 0) begin errors++; $display("[TB] FAIL basic_no_pulses: got fe=%0d ov=%0d expected 0 0", fe_count - fe_base, ov_count - ov_base); end
        tick(5);
    endtask

    task automatic test_glitch;
        fe_base = fe_count;
        ov_base = ov_count;
        tick(1);
        rx = 1'b0;
        tick(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_edge2: got %b expected 0", busy); end
        tick(1);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy_edge3: got %b expected 1", busy); end
        tick(1);
        rx = 1'b1;
        tick(6);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL glitch_busy_edge10: got %b expected 1", busy); end
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy_edge11: got %b expected 0", busy); end
        tick(20);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL glitch_valid: got %b expected 0", rx_valid); end
        checks++; if (fe_count - fe_base !== 0 || ov_count - ov_base !== 0) begin errors++; $display("[TB] FAIL glitch_no_pulses: got fe=%0d ov=%0d expected 0 0", fe_count - fe_base, ov_count - ov_base); end
    endtask

    task automatic test_frame_err;
        fe_base = fe_count;
        tick(1);
        drive_bits(8'h3C, 1'b0);
        tick(10);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL ferr_edge154: got %b expected 0", frame_err); end
        tick(1);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL ferr_edge155: got %b expected 1", frame_err); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL ferr_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_data !== 8'hA5) begin errors++; $display("[TB] FAIL ferr_data_kept: got %h expected a5", rx_data); end
        tick(1);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL ferr_edge156: got %b expected 0", frame_err); end
        tick(44);
        rx = 1'b1;
        tick(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ferr_busy_break: got %b expected 1", busy); end
        tick(1);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ferr_busy_release: got %b expected 0", busy); end
        checks++; if (fe_count - fe_base !== 1) begin errors++; $display("[TB] FAIL ferr_pulse_count: got %0d expected 1", fe_count - fe_base); end
        tick(5);
    endtask

    task automatic test_back_to_back;
        ov_base = ov_count;
        tick(1);
        drive_bits(8'h11, 1'b1);
        tick(11);
        checks++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first: got data=%h valid=%b expected 11 1", rx_data, rx_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first_overrun: got %b expected 0", overrun); end
        tick(5);
        drive_bits(8'h22, 1'b1);
        tick(11);
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL b2b_overrun: got %b expected 1", overrun); end
        checks++; if (rx_data !== 8'h22 || rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second: got data=%h valid=%b expected 22 1", rx_data, rx_valid); end
        tick(1);
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun_width: got %b expected 0", overrun); end
        checks++; if (ov_count - ov_base !== 1) begin errors++; $display("[TB] FAIL b2b_overrun_count: got %0d expected 1", ov_count - ov_base); end

        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(3);
        ov_base = ov_count;
        tick(1);
        drive_bits(8'h11, 1'b1);
        tick(11);
        checks++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_first: got data=%h valid=%b expected 11 1", rx_data, rx_valid); end
        tick(5);
        drive_bits(8'h22, 1'b1);
        tick(10);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_overrun: got %b expected 0", overrun); end
        checks++; if (rx_data !== 8'h22 || rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_second: got data=%h valid=%b expected 22 1", rx_data, rx_valid); end
        tick(3);
        checks++; if (ov_count - ov_base !== 0) begin errors++; $display("[TB] FAIL b2b_ready_overrun_count: got %0d expected 0", ov_count - ov_base); end
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        tick(5);
    endtask

    task automatic test_mid_frame_reset;
        tick(1);
        rx = 1'b0;
        tick(B);
        rx = 1'b1;
        tick(70 - B);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL midrst_rx_data: got %h expected 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
        checks++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pulses: got fe=%b ov=%b expected 0 0", frame_err, overrun); end
        fe_base = fe_count;
        ov_base = ov_count;
        tick(79);
        checks++; if (busy !== 1'b0 || rx_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_idle: got busy=%b valid=%b expected 0 0", busy, rx_valid); end
        tick(9);
        drive_bits(8'h5A, 1'b1);
        tick(11);
        checks++; if (rx_data !== 8'h5A || rx_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_clean_frame: got data=%h valid=%b expected 5a 1", rx_data, rx_valid); end
        tick(3);
        checks++; if (fe_count - fe_base !== 0 || ov_count - ov_base !== 0) begin errors++; $display("[TB] FAIL midrst_no_pulses: got fe=%0d ov=%0d expected 0 0", fe_count - fe_base, ov_count - ov_base); end
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        rx_ready = 1'b0;
        test_reset();
        test_basic_frame();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_mid_frame_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It is the receive-side counterpart of the transmit path and shares the same bit-time convention, CLKS_PER_BIT system clocks per bit. The block synchronises the raw line, validates the start bit at mid-bit, and samples each data bit and the stop bit at bit centre. It delivers each byte through a valid/ready holding register with overrun and framing-error flags.

## Interface
- CLKS_PER_BIT, default 5208: clocks per bit (9600 baud at 50 MHz). Legal range is 4 or more.
- CW, default 13: bit-counter width. Must hold CLKS_PER_BIT-1.
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high. Clock is clk.
- rx  input  1  raw serial line, asynchronous, idle high.
- rx_data  output  8  last received byte. Reset 0x00.
- rx_valid  output  1  rx_data holds an unconsumed byte. Reset 0.
- rx_ready  input  1  consumer accepts rx_data.
- frame_err  output  1  one-cycle pulse: stop bit sampled low. Reset 0.
- overrun  output  1  one-cycle pulse: byte completed while the previous byte was unconsumed. Reset 0.
- busy  output  1  high whenever state is not IDLE. Reset 0.

## Operation
- Synchroniser: two flops, rx to rx_meta to rx_s. Both reset to 1. All logic uses rx_s only.
- Definitions: H = CLKS_PER_BIT/2 (integer division). B = CLKS_PER_BIT. The counter counts down. Each state acts when count reaches 0.
- IDLE:
  - If rx_s==0: go to START and load count=H-1.
- START (count reaches 0):
  - Sample rx_s. If 0: go to DATA, load count=B-1, set bit index=0.
  - If rx_s is 1: the low was a glitch. Return to IDLE with no output activity.
- DATA (count reaches 0):
  - Shift rx_s into the MSB of the shift register, shifting right, so the byte ends up LSB-first.
  - Increment bit index and reload count=B-1.
  - After the 8th sample, go to STOP.
- STOP (count reaches 0), rx_s==1:
  - Load rx_data with the shift register and set rx_valid=1.
  - If rx_valid was already 1 and is not being consumed this cycle, pulse overrun. The new byte overwrites rx_data.
  - Go to IDLE.
- STOP (count reaches 0), rx_s==0:
  - Pulse frame_err. The byte is discarded; rx_data and rx_valid are unchanged.
  - Go to BREAK.
- BREAK:
  - Wait for rx_s==1, then go to IDLE. A held-low line (break) never restarts reception.
- Handshake:
  - rx_valid and rx_ready both high at a clock edge: rx_valid clears after that edge.
  - Consume and byte completion in the same cycle: the new byte loads, rx_valid stays 1, and there is no overrun.
- rx_data is stable while rx_valid=1, except when overwritten on overrun.
- Reset at any point, including mid-frame, forces:
  - state IDLE, counter 0, bit index 0, shift register 0;
  - sync flops 1;
  - all outputs to their reset values on the next edge.
  - No partial byte is delivered.

## Timing
- Count edges from the first clk edge at which rx is low (edge 0). Then:
  - START is entered at edge 3.
  - The start bit is sampled at edge H+3.
  - Data bit k (k=0..7) is sampled at edge H+3+(k+1)·B.
  - The stop bit is sampled at edge H+3+9·B. rx_valid, frame_err and overrun update on that edge.
- busy rises at edge 3 and falls on the edge that returns to IDLE.
- Back-to-back frames are supported. A new start edge is accepted in the cycle after the return to IDLE, which is half a bit before the nominal end of the stop bit.
- frame_err and overrun are exactly one cycle wide.
- The baud mismatch tolerated is about ±4%, from mid-bit sampling over 10 bits.

## Test plan
All scenarios use CLKS_PER_BIT=16, so H=8 and the stop bit is sampled at edge 155.
- Frame 0xA5 with rx_ready=0:
  - rx_valid rises at edge 155 with rx_data=0xA5 and stays high.
  - Pulse rx_ready for 1 cycle: rx_valid is 0 on the next cycle.
- rx low for 4 cycles, then high:
  - busy pulses; there is no rx_valid, frame_err or overrun.
  - State returns to IDLE at edge 11.
- Frame 0x3C with the stop bit driven low, line held low for 40 more cycles:
  - frame_err is a 1-cycle pulse at edge 155; rx_valid stays 0.
  - busy stays high until 3 cycles after rx returns high.
- Frames 0x11 then 0x22 back-to-back with rx_ready=0:
  - The second completion pulses overrun; rx_data=0x22 and rx_valid=1.
  - Repeat with rx_ready=1 in the completion cycle: no overrun.
- rst asserted for 1 cycle during data bit 3 of frame 0xFF:
  - All outputs are at reset values after that edge.
  - A following clean frame 0x5A yields rx_data=0x5A, with no frame_err and no overrun.
